// File: rtl/mdio_ctrl_pkg.sv
// Shared definitions for the MDIO command path: state encoding, default baud
// divider and the bit positions of the command word fields.
package mdio_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK,
      WAITNEXT,
      HOLD
   } stateT;

   localparam int unsigned DefaultBaudRateDivider = 1085;

   localparam int unsigned PhyLo  = 0;
   localparam int unsigned PhyHi  = 4;
   localparam int unsigned RegLo  = 5;
   localparam int unsigned RegHi  = 9;
   localparam int unsigned CtrlLo = 10;
   localparam int unsigned CtrlHi = 13;
   localparam int unsigned OpLo   = 14;
   localparam int unsigned OpHi   = 15;
   localparam int unsigned DataLo = 16;
   localparam int unsigned DataHi = 31;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: line synchroniser plus start/data/stop/break bit timing.
// byteValid and falseStart are same-cycle strobes so the assembler adds no latency.
module uart_byte_rx
   import mdio_ctrl_pkg::*;
#(
   parameter int unsigned BaudRateDivider = DefaultBaudRateDivider
) (
   input  logic       clk125,
   input  logic       reset_n,
   input  logic       rxd,
   input  logic       startReq,
   output logic       rxs,
   output logic       byteValid,
   output logic [7:0] byteData,
   output logic       falseStart,
   output logic       inFrame,
   output logic       frameErr
);

   localparam int unsigned BitW = $clog2(BaudRateDivider);
   localparam logic [BitW-1:0] HalfBit = BitW'(BaudRateDivider / 2 - 1);
   localparam logic [BitW-1:0] FullBit = BitW'(BaudRateDivider - 1);

   stateT           state;
   logic            syncQ;
   logic [BitW-1:0] bitcnt;
   logic [2:0]      bitidx;
   logic [7:0]      shreg;

   assign inFrame    = (state != IDLE);
   assign byteData   = shreg;
   assign byteValid  = (state == STOP) && (bitcnt == '0) && rxs;
   assign falseStart = (state == START) && (bitcnt == '0) && rxs;

   always_ff @(posedge clk125) begin
      if (!reset_n) begin
         syncQ    <= 1'b1;
         rxs      <= 1'b1;
         state    <= IDLE;
         bitcnt   <= '0;
         bitidx   <= '0;
         shreg    <= '0;
         frameErr <= 1'b0;
      end else begin
         syncQ    <= rxd;
         rxs      <= syncQ;
         frameErr <= 1'b0;
         case (state)
            IDLE: begin
               if (startReq) begin
                  bitcnt <= HalfBit;
                  state  <= START;
               end
            end
            START: begin
               if (bitcnt != '0) begin
                  bitcnt <= bitcnt - 1'b1;
               end else if (!rxs) begin
                  bitcnt <= FullBit;
                  bitidx <= '0;
                  state  <= DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (bitcnt != '0) begin
                  bitcnt <= bitcnt - 1'b1;
               end else begin
                  shreg[bitidx] <= rxs;
                  bitcnt        <= FullBit;
                  if (bitidx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bitidx <= bitidx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bitcnt != '0) begin
                  bitcnt <= bitcnt - 1'b1;
               end else if (rxs) begin
                  state <= IDLE;
               end else begin
                  frameErr <= 1'b1;
                  state    <= BREAK;
               end
            end
            BREAK: begin
               // One frame_err per break regardless of its length.
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles little-endian command words from UART bytes and holds each word on a
// valid/ready interface; partial frames are dropped on timeout or framing error.
module uart_cmd_deframer
   import mdio_ctrl_pkg::*;
#(
   parameter int unsigned BaudRateDivider = DefaultBaudRateDivider,
   parameter int unsigned CmdBytes        = 4,
   parameter int unsigned ByteTimeout     = 16777215
) (
   input  logic                  clk125,
   input  logic                  reset_n,
   input  logic                  rxd,
   output logic [8*CmdBytes-1:0] cmd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  timeout_err,
   output logic                  overrun_err
);

   localparam int unsigned TmoW = $clog2(ByteTimeout + 1);
   localparam int unsigned CntW = $clog2(CmdBytes + 1);
   localparam logic [TmoW-1:0] TmoLoad  = TmoW'(ByteTimeout);
   localparam logic [CntW-1:0] LastByte = CntW'(CmdBytes - 1);

   stateT           state;
   logic [TmoW-1:0] tmo;
   logic [CntW-1:0] bytecnt;
   logic            rxsQ;
   logic            ovrArmed;

   logic            rxs;
   logic            startReq;
   logic            byteValid;
   logic [7:0]      byteData;
   logic            falseStart;
   logic            inFrame;

   // Receiver may only start from our idle/wait states, and never while it is in BREAK.
   assign startReq = ((state == IDLE) || (state == WAITNEXT)) && !inFrame && !rxs;
   assign busy     = (state != IDLE) || inFrame;

   uart_byte_rx #(
      .BaudRateDivider(BaudRateDivider)
   ) u_byte_rx (
      .clk125    (clk125),
      .reset_n   (reset_n),
      .rxd       (rxd),
      .startReq  (startReq),
      .rxs       (rxs),
      .byteValid (byteValid),
      .byteData  (byteData),
      .falseStart(falseStart),
      .inFrame   (inFrame),
      .frameErr  (frame_err)
   );

   always_ff @(posedge clk125) begin
      if (!reset_n) begin
         state       <= IDLE;
         tmo         <= '0;
         bytecnt     <= '0;
         rxsQ        <= 1'b1;
         ovrArmed    <= 1'b1;
         cmd_data    <= '0;
         cmd_valid   <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         rxsQ        <= rxs;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         case (state)
            IDLE: begin
               ovrArmed <= 1'b1;
               if (startReq) begin
                  state <= START;
               end
            end
            START: begin
               if (byteValid) begin
                  cmd_data <= {byteData, cmd_data[8*CmdBytes-1:8]};
                  bytecnt  <= bytecnt + 1'b1;
                  if (bytecnt == LastByte) begin
                     cmd_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     tmo   <= TmoLoad;
                     state <= WAITNEXT;
                  end
               end else if (falseStart) begin
                  if (bytecnt == '0) begin
                     state <= IDLE;
                  end else begin
                     tmo   <= TmoLoad;
                     state <= WAITNEXT;
                  end
               end else if (frame_err) begin
                  bytecnt <= '0;
                  state   <= IDLE;
               end
            end
            WAITNEXT: begin
               if (startReq) begin
                  state <= START;
               end else if (tmo == '0) begin
                  timeout_err <= 1'b1;
                  bytecnt     <= '0;
                  state       <= IDLE;
               end else begin
                  tmo <= tmo - 1'b1;
               end
            end
            HOLD: begin
               if (ovrArmed && rxsQ && !rxs) begin
                  overrun_err <= 1'b1;
                  ovrArmed    <= 1'b0;
               end
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  bytecnt   <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks them
// on every valid cycle and pops on transfer; error pulses are tallied and checked.
module tb_uart_cmd_deframer;

   localparam int unsigned Div = 16;

   logic        clk125 = 1'b0;
   logic        reset_n;
   logic        rxd;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        busy;
   logic        frame_err;
   logic        timeout_err;
   logic        overrun_err;

   int checks = 0;
   int failures = 0;
   int validCycles = 0;
   int frameCnt = 0;
   int timeoutCnt = 0;
   int overrunCnt = 0;
   logic prevXfer = 1'b0;
   logic [31:0] expQ[$];

   uart_cmd_deframer #(
      .BaudRateDivider(Div),
      .CmdBytes       (4),
      .ByteTimeout    (200)
   ) dut (
      .clk125     (clk125),
      .reset_n    (reset_n),
      .rxd        (rxd),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .timeout_err(timeout_err),
      .overrun_err(overrun_err)
   );

   always #5 clk125 = ~clk125;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk125) begin
      if (reset_n === 1'b1) begin
         if (prevXfer) chk("valid_drop", {31'd0, cmd_valid}, 32'd0);
         prevXfer = cmd_valid && cmd_ready;
         if (cmd_valid) begin
            validCycles++;
            if (expQ.size() == 0) begin
               chk("unexpected_word", cmd_data, 32'hxxxxxxxx);
            end else begin
               chk("cmd_data", cmd_data, expQ[0]);
               if (cmd_ready) void'(expQ.pop_front());
            end
         end
         if (frame_err) frameCnt++;
         if (timeout_err) timeoutCnt++;
         if (overrun_err) overrunCnt++;
      end else begin
         prevXfer = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk125);
         #1;
      end
   endtask

   task automatic sendBit(input logic v);
      rxd = v;
      tick(Div);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(stopBit);
      rxd = 1'b1;
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], 1'b1);
   endtask

   task automatic waitValid(input string name);
      int n = 0;
      while (!cmd_valid && n < 400) begin
         tick(1);
         n++;
      end
      chk(name, {31'd0, cmd_valid}, 32'd1);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         tick(1);
         n++;
      end
      chk(name, expQ.size(), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      rxd       = 1'b1;
      cmd_ready = 1'b0;
      tick(3);
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_data", cmd_data, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_errs", {29'd0, frame_err, timeout_err, overrun_err}, 32'd0);
      reset_n = 1'b1;
      tick(5);

      // Basic frame with ready held high: one-cycle valid.
      cmd_ready   = 1'b1;
      validCycles = 0;
      expQ.push_back(32'h87654321);
      sendWord(32'h87654321);
      tick(10);
      chk("t1_valid_cycles", validCycles, 32'd1);
      waitDrain("t1_drain");
      chk("t1_errs", frameCnt + timeoutCnt + overrunCnt, 32'd0);

      // Back-pressure plus one byte arriving during HOLD.
      cmd_ready = 1'b0;
      expQ.push_back(32'h87654321);
      sendWord(32'h87654321);
      waitValid("t2_valid");
      tick(50);
      chk("t2_busy_hold", {31'd0, busy}, 32'd1);
      sendByte(8'h5A, 1'b1);
      tick(4);
      chk("t2_still_valid", {31'd0, cmd_valid}, 32'd1);
      cmd_ready = 1'b1;
      waitDrain("t2_drain");
      tick(2);
      chk("t2_overrun", overrunCnt, 32'd1);
      expQ.push_back(32'h44332211);
      sendWord(32'h44332211);
      waitDrain("t2_next_word");

      // Framing error followed by a long break.
      sendByte(8'h55, 1'b0);
      rxd = 1'b0;
      tick(100);
      chk("t3_busy_break", {31'd0, busy}, 32'd1);
      chk("t3_frame_err", frameCnt, 32'd1);
      rxd = 1'b1;
      tick(6);
      chk("t3_busy_idle", {31'd0, busy}, 32'd0);
      expQ.push_back(32'h04030201);
      sendWord(32'h04030201);
      waitDrain("t3_word");
      chk("t3_frame_once", frameCnt, 32'd1);

      // Inter-byte timeout drops the partial frame.
      sendByte(8'h12, 1'b1);
      sendByte(8'h34, 1'b1);
      tick(250);
      chk("t4_timeout", timeoutCnt, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      expQ.push_back(32'hDDCCBBAA);
      sendWord(32'hDDCCBBAA);
      waitDrain("t4_word");

      // Short glitch: false start only.
      validCycles = 0;
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(2);
      chk("t5_busy_start", {31'd0, busy}, 32'd1);
      tick(20);
      chk("t5_busy_idle", {31'd0, busy}, 32'd0);
      chk("t5_no_valid", validCycles, 32'd0);
      chk("t5_errs", frameCnt + timeoutCnt + overrunCnt, 32'd3);

      // Reset in the middle of byte 3.
      sendByte(8'h99, 1'b1);
      sendByte(8'h88, 1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      reset_n = 1'b0;
      rxd     = 1'b1;
      tick(1);
      chk("t6_rst_data", cmd_data, 32'd0);
      chk("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_errs", {29'd0, frame_err, timeout_err, overrun_err}, 32'd0);
      reset_n = 1'b1;
      tick(20);
      expQ.push_back(32'hC0FFEE42);
      sendWord(32'hC0FFEE42);
      waitDrain("t6_word");
      tick(10);
      chk("final_errs", frameCnt + timeoutCnt + overrunCnt, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
